thresholding_cfg_loader: RTL and testbench



---
 rtl/thresholding_cfg_loader.sv | 189 ++++++++++++++++++
 tb/tb_thresholding_cfg_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/thresholding_cfg_loader.sv
// rtl/thresholding_cfg_loader.sv - threshold configuration sequencer for the thresholding core
//
// Takes a channel-major stream of thresholds and writes each value into the
// core's configuration port. The address is {cf, pe, idx}. Within each channel
// the thresholds must rise strictly, and a value that does not sets err[0].
// When VERIFY is set, every location is read back afterwards. The sum of the
// read-back values is compared against the sum of the written values.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             begin a load (accepted in IDLE/DONE only)
//   busy, done, err   status; err[0] ordering, err[1] readback mismatch/timeout
//   s_tvalid/s_tready/s_tdata   threshold stream
//   cfg_en/cfg_we/cfg_a/cfg_d   configuration access to the core
//   cfg_rack/cfg_q              readback acknowledge and data from the core
module thresholding_cfg_loader #(
  parameter int N      = 2,
  parameter int K      = 8,
  parameter int C      = 4,
  parameter int PE     = 2,
  parameter int SIGNED = 1,
  parameter int VERIFY = 1,
  localparam int CF    = C / PE,
  localparam int AW    = $clog2(CF) + $clog2(PE) + N
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [1:0]    err,
  input  logic          s_tvalid,
  output logic          s_tready,
  input  logic [K-1:0]  s_tdata,
  output logic          cfg_en,
  output logic          cfg_we,
  output logic [AW-1:0] cfg_a,
  output logic [K-1:0]  cfg_d,
  input  logic          cfg_rack,
  input  logic [K-1:0]  cfg_q
);

  localparam int NT    = 2**N - 1;
  localparam int TOTAL = C * NT;
  localparam int PW    = $clog2(PE);
  localparam int FW    = $clog2(CF);
  localparam int PCW   = (PW > 0) ? PW : 1;
  localparam int FCW   = (FW > 0) ? FW : 1;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int SW    = K + CW;
  localparam int TW    = $clog2(N + 3);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [N-1:0]    idx, idx_nxt;
  logic [PCW-1:0]  pe_c, pe_nxt;
  logic [FCW-1:0]  cf_c, cf_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   rcnt, rcnt_nxt;
  logic [SW-1:0]   wsum, rsum, rsum_nxt;
  logic [K-1:0]    prev;
  logic [TW-1:0]   tmr;
  logic [1:0]      err_q;
  logic            s_tready_q;
  logic            wr_hs, rd_iss, adv, last, rack_ok, viol;
  logic            start_acc, set_err1;

  assign wr_hs     = (state == S_WRITE) && s_tvalid;
  assign rd_iss    = (state == S_READ);
  assign adv       = wr_hs || rd_iss;
  assign last      = (cnt == CW'(TOTAL - 1));
  assign start_acc = start && ((state == S_IDLE) || (state == S_DONE));

  // Racks past the TOTAL-th are ignored so a chattering core cannot push the
  // checksum past what was written.
  assign rack_ok  = ((state == S_READ) || (state == S_DRAIN)) && cfg_rack &&
                    (rcnt != CW'(TOTAL));
  assign rsum_nxt = rack_ok ? rsum + SW'(cfg_q) : rsum;
  assign rcnt_nxt = rack_ok ? rcnt + CW'(1) : rcnt;

  always_comb begin
    viol = 1'b0;
    if (wr_hs && (idx != '0)) begin
      if (SIGNED != 0) viol = ($signed(s_tdata) <= $signed(prev));
      else             viol = (s_tdata <= prev);
    end
  end

  // Address counters: idx fastest, then pe, then cf. They wrap to zero after the
  // last location, so READ walks the same order without an explicit reload.
  always_comb begin
    idx_nxt = idx;
    pe_nxt  = pe_c;
    cf_nxt  = cf_c;
    if (adv) begin
      if (idx == N'(NT - 1)) begin
        idx_nxt = '0;
        if (pe_c == PCW'(PE - 1)) begin
          pe_nxt = '0;
          cf_nxt = (cf_c == FCW'(CF - 1)) ? '0 : cf_c + FCW'(1);
        end else begin
          pe_nxt = pe_c + PCW'(1);
        end
      end else begin
        idx_nxt = idx + N'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    set_err1  = 1'b0;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_WRITE;
      S_WRITE: if (wr_hs && last) state_nxt = (VERIFY != 0) ? S_READ : S_DONE;
      S_READ:  if (last) state_nxt = S_DRAIN;
      S_DRAIN: begin
        // The rack arriving this cycle counts, so done follows the final rack.
        if (rcnt_nxt == CW'(TOTAL)) begin
          state_nxt = S_DONE;
          set_err1  = (rsum_nxt != wsum);
        end else if (tmr == TW'(N + 2)) begin
          state_nxt = S_DONE;
          set_err1  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      s_tready_q <= 1'b0;
      idx        <= '0;
      pe_c       <= '0;
      cf_c       <= '0;
      cnt        <= '0;
      rcnt       <= '0;
      wsum       <= '0;
      rsum       <= '0;
      prev       <= '0;
      tmr        <= '0;
      err_q      <= 2'b00;
    end else begin
      state      <= state_nxt;
      s_tready_q <= (state_nxt == S_WRITE);
      if (start_acc) begin
        idx   <= '0;
        pe_c  <= '0;
        cf_c  <= '0;
        cnt   <= '0;
        rcnt  <= '0;
        wsum  <= '0;
        rsum  <= '0;
        tmr   <= '0;
        err_q <= 2'b00;
      end else begin
        idx  <= idx_nxt;
        pe_c <= pe_nxt;
        cf_c <= cf_nxt;
        rcnt <= rcnt_nxt;
        rsum <= rsum_nxt;
        if (adv) cnt <= last ? '0 : cnt + CW'(1);
        if (wr_hs) begin
          wsum <= wsum + SW'(s_tdata);
          prev <= s_tdata;
        end
        if (viol) err_q[0] <= 1'b1;
        if (state == S_DRAIN) tmr <= tmr + TW'(1);
        if (set_err1) err_q[1] <= 1'b1;
      end
    end
  end

  always_comb begin
    cfg_a = AW'(idx) | (AW'(pe_c) << N) | (AW'(cf_c) << (N + PW));
  end

  assign cfg_en   = wr_hs || rd_iss;
  assign cfg_we   = wr_hs;
  assign cfg_d    = (state == S_WRITE) ? s_tdata : '0;
  assign s_tready = s_tready_q;
  assign busy     = (state == S_WRITE) || (state == S_READ) || (state == S_DRAIN);
  assign done     = (state == S_DONE);
  assign err      = err_q;

endmodule

// File: tb/tb_thresholding_cfg_loader.sv
// tb/tb_thresholding_cfg_loader.sv - directed bench for thresholding_cfg_loader
module tb_thresholding_cfg_loader;

  localparam int N  = 2;
  localparam int K  = 8;
  localparam int C  = 4;
  localparam int PE = 2;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          s_tvalid = 1'b0;
  logic [K-1:0]  s_tdata = '0;

  logic          busy, done, s_tready, cfg_en, cfg_we, cfg_rack;
  logic [1:0]    err;
  logic [AW-1:0] cfg_a;
  logic [K-1:0]  cfg_d, cfg_q;

  logic          busy2, done2, s_tready2, cfg_en2, cfg_we2;
  logic [1:0]    err2;
  logic [AW-1:0] cfg_a2;
  logic [K-1:0]  cfg_d2;
  logic          cfg_rack2 = 1'b0;
  logic [K-1:0]  cfg_q2 = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  thresholding_cfg_loader #(.N(N), .K(K), .C(C), .PE(PE), .SIGNED(1), .VERIFY(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .cfg_en(cfg_en), .cfg_we(cfg_we), .cfg_a(cfg_a), .cfg_d(cfg_d),
    .cfg_rack(cfg_rack), .cfg_q(cfg_q)
  );

  thresholding_cfg_loader #(.N(N), .K(K), .C(C), .PE(PE), .SIGNED(1), .VERIFY(0)) u_dut_nv (
    .clk(clk), .rst(rst), .start(start), .busy(busy2), .done(done2), .err(err2),
    .s_tvalid(s_tvalid), .s_tready(s_tready2), .s_tdata(s_tdata),
    .cfg_en(cfg_en2), .cfg_we(cfg_we2), .cfg_a(cfg_a2), .cfg_d(cfg_d2),
    .cfg_rack(cfg_rack2), .cfg_q(cfg_q2)
  );

  // Core model: stores writes, returns readback N cycles after each issue.
  logic [K-1:0] mem [16];
  logic [N-1:0] pv = '0;
  logic [K-1:0] pd [N];
  int           rb_n = 0;
  int           corrupt_at = -1;
  int           drop_at = -1;
  logic         clr_model = 1'b0;

  always @(posedge clk) begin
    if (cfg_en && cfg_we) mem[cfg_a] <= cfg_d;
    pv[0] <= cfg_en && !cfg_we && (rb_n != drop_at);
    pd[0] <= mem[cfg_a] + ((rb_n == corrupt_at) ? 8'd1 : 8'd0);
    for (int i = 1; i < N; i++) begin
      pv[i] <= pv[i-1];
      pd[i] <= pd[i-1];
    end
    if (clr_model) rb_n <= 0;
    else if (cfg_en && !cfg_we) rb_n <= rb_n + 1;
  end
  assign cfg_rack = pv[N-1];
  assign cfg_q    = pd[N-1];

  // Access log, sampled mid-cycle.
  logic [AW-1:0] wa[$];
  logic [K-1:0]  wd[$];
  logic [AW-1:0] ra[$];
  logic [AW-1:0] wa2[$];
  int            wsum2 = 0;
  int            rb2_n = 0;

  always @(negedge clk) begin
    if (clr_model) begin
      wa.delete(); wd.delete(); ra.delete(); wa2.delete();
      wsum2 = 0;
      rb2_n = 0;
    end else begin
      if (cfg_en && cfg_we) begin wa.push_back(cfg_a); wd.push_back(cfg_d); end
      if (cfg_en && !cfg_we) ra.push_back(cfg_a);
      if (cfg_en2 && cfg_we2) begin wa2.push_back(cfg_a2); wsum2 = wsum2 + int'(cfg_d2); end
      if (cfg_en2 && !cfg_we2) rb2_n = rb2_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [AW-1:0] exp_a [12] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6,
                               4'd8, 4'd9, 4'd10, 4'd12, 4'd13, 4'd14};
  logic [K-1:0]  vals [12];

  task automatic set_vals(input logic bad);
    for (int i = 0; i < 12; i++) vals[i] = K'(i + 1);
    if (bad) begin vals[6] = 8'd9; vals[7] = 8'd8; vals[8] = 8'd9; end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_err"}, err, 2'b00);
    check({tag, "_tready"}, s_tready, 1'b0);
    check({tag, "_en"}, cfg_en, 1'b0);
    check({tag, "_we"}, cfg_we, 1'b0);
    check({tag, "_a"}, cfg_a, 0);
    check({tag, "_d"}, cfg_d, 0);
  endtask

  task automatic run(input string tag, input logic [11:0] gap_mask, input int corrupt,
                     input int drop, input logic [1:0] exp_err, input int exp_k);
    int   i, k, k2, sum;
    logic gapped;
    corrupt_at = corrupt;
    drop_at    = drop;
    clr_model  = 1'b1;
    start      = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    clr_model = 1'b0;
    i = 0;
    gapped = 1'b0;
    sum = 0;
    while (i < 12) begin
      if (gap_mask[i] && !gapped) begin
        s_tvalid = 1'b0;
        @(negedge clk);
        check({tag, "_gap_en"}, cfg_en, 1'b0);
        gapped = 1'b1;
      end else begin
        s_tvalid = 1'b1;
        s_tdata  = vals[i];
        sum      = sum + int'(vals[i]);
        @(negedge clk);
        if (i == 0) begin
          check({tag, "_done_drop"}, done, 1'b0);
          check({tag, "_busy"}, busy, 1'b1);
          check({tag, "_tready"}, s_tready, 1'b1);
        end
        check({tag, "_beat_en"}, cfg_en, 1'b1);
        i++;
        gapped = 1'b0;
      end
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    s_tdata  = '0;
    k  = 0;
    k2 = 0;
    for (int j = 1; j <= 100; j++) begin
      @(negedge clk);
      if (done2 && k2 == 0) k2 = j;
      if (done) begin k = j; break; end
      @(posedge clk); #1;
    end
    check({tag, "_done_lat"}, k, exp_k);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_cfg_en_done"}, cfg_en, 1'b0);
    check({tag, "_nwr"}, wa.size(), 12);
    check({tag, "_nrb"}, ra.size(), 12);
    for (int j = 0; j < 12 && j < wa.size(); j++) begin
      check({tag, "_wa"}, wa[j], exp_a[j]);
      check({tag, "_wd"}, wd[j], vals[j]);
    end
    for (int j = 0; j < 12 && j < ra.size(); j++) check({tag, "_ra"}, ra[j], exp_a[j]);
    check({tag, "_nv_done_lat"}, k2, 1);
    check({tag, "_nv_err"}, err2, {1'b0, exp_err[0]});
    check({tag, "_nv_rb"}, rb2_n, 0);
    check({tag, "_nv_nwr"}, wa2.size(), 12);
    for (int j = 0; j < 12 && j < wa2.size(); j++) check({tag, "_nv_wa"}, wa2[j], exp_a[j]);
    check({tag, "_nv_wsum"}, wsum2, sum);
  endtask

  initial begin
    for (int j = 0; j < N; j++) pd[j] = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset("rst0");
    check("rst0_nv_busy", busy2, 1'b0);
    check("rst0_nv_tready", s_tready2, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    set_vals(1'b0);
    run("base", 12'h000, -1, -1, 2'b00, 15);
    check("base_sum78", wsum2, 78);
    run("gaps", 12'b0100_1010_0110, -1, -1, 2'b00, 15);
    set_vals(1'b1);
    run("order", 12'h000, -1, -1, 2'b01, 15);
    set_vals(1'b0);
    run("corrupt", 12'h000, 4, -1, 2'b10, 15);
    run("drop", 12'h000, -1, 4, 2'b10, 18);

    // Abort mid-write after five beats.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int j = 0; j < 5; j++) begin
      s_tvalid = 1'b1;
      s_tdata  = vals[j];
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    s_tdata  = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset("abort");
    run("restart", 12'h000, -1, -1, 2'b00, 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
